// File: rtl/bpsk_demodulator.sv
// bpsk_demodulator: coherent BPSK receiver built around a Costas loop.
// A phase-accumulator NCO drives I (cosine) and Q (sine) indexes into an
// external cosine LUT with one clock of read latency. Both arms mix the
// delayed sample with the returned carrier, low-pass it, and feed a
// decision-directed phase detector whose PI loop filter steers the NCO.
// Hard bits are the registered sign of the I arm.
// Optional feature: define BPSK_DEMOD_LOCK_DETECT_EN to add the `locked`
// output and its consecutive-cycle lock counter.
module bpsk_demodulator #(
  parameter  int DATA_W    = 16,
  parameter  int LUT_N     = 4096,
  parameter  int ACC_FRAC  = 16,
  parameter  int LPF_SHIFT = 3,
  parameter  int KP_SHIFT  = 4,
  parameter  int KI_SHIFT  = 10,
  localparam int PHASE_W   = $clog2(LUT_N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [DATA_W-1:0]  data_in,
  output logic                      data_out,
  output logic        [PHASE_W-1:0] nco_i_cosine_lu_angle_steps,
  output logic        [PHASE_W-1:0] nco_q_cosine_lu_angle_steps,
  input  logic signed [DATA_W-1:0]  nco_carrier_i,
  input  logic signed [DATA_W-1:0]  nco_carrier_q
`ifdef BPSK_DEMOD_LOCK_DETECT_EN
  ,
  output logic                      locked
`endif
);

  localparam int ACC_W = PHASE_W + ACC_FRAC;
  localparam int LPF_W = DATA_W + 2;

  // Nominal carrier is fclk/8: an eighth of the LUT per clock.
  localparam logic [ACC_W-1:0]   NOM_INC = ACC_W'(LUT_N / 8) << ACC_FRAC;
  // Sine is the cosine read a quarter period earlier.
  localparam logic [PHASE_W-1:0] QUARTER = PHASE_W'(LUT_N / 4);

  localparam logic signed [2*DATA_W-1:0] PROD_MAX = (2*DATA_W)'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [DATA_W-1:0]   MIX_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [LPF_W-1:0]    ERR_MAX  = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [LPF_W-1:0]    ERR_MIN  = {3'b111, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W:0]      INTEG_MAX = (ACC_W+1)'(1) << (ACC_W - 3);
  localparam logic signed [ACC_W:0]      INTEG_MIN = -INTEG_MAX;

  logic        [ACC_W-1:0]   acc_reg;
  logic        [ACC_W-1:0]   acc_next;
  logic        [PHASE_W-1:0] i_idx_reg;
  logic        [PHASE_W-1:0] q_idx_reg;
  logic        [PHASE_W-1:0] i_idx_next;
  logic signed [DATA_W-1:0]  data_d_reg;
  logic signed [LPF_W-1:0]   lpf_i;
  logic signed [LPF_W-1:0]   lpf_q;
  logic signed [LPF_W-1:0]   err_wide;
  logic signed [DATA_W-1:0]  err;
  logic signed [ACC_W-1:0]   err_ext;
  logic signed [ACC_W-1:0]   kp_term;
  logic signed [ACC_W-1:0]   ki_term;
  logic signed [ACC_W:0]     integ_sum;
  logic signed [ACC_W-1:0]   integ_reg;
  logic signed [ACC_W-1:0]   integ_next;
  logic signed [ACC_W-1:0]   ctrl;
  logic                      data_out_reg;

  // ---------------------------------------------------------------------
  // NCO: the wrap of the accumulator is the natural modulo of the carrier.
  // ---------------------------------------------------------------------
  assign acc_next   = acc_reg + NOM_INC + ctrl;
  assign i_idx_next = acc_next[ACC_W-1 -: PHASE_W];

  // Phase accumulator and registered LUT indexes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      i_idx_reg <= '0;
      q_idx_reg <= '0;
    end else begin
      acc_reg   <= acc_next;
      i_idx_reg <= i_idx_next;
      q_idx_reg <= i_idx_next - QUARTER;
    end
  end

  assign nco_i_cosine_lu_angle_steps = i_idx_reg;
  assign nco_q_cosine_lu_angle_steps = q_idx_reg;

  // Delay the sample one clock so it meets the carrier read back from the LUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_d_reg <= '0;
    else     data_d_reg <= data_in;
  end

  // ---------------------------------------------------------------------
  // Mixer + one-pole IIR per arm (arm 0 = I, arm 1 = Q).
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_arm
      logic signed [DATA_W-1:0]   carrier;
      logic signed [2*DATA_W-1:0] prod;
      logic signed [2*DATA_W-1:0] prod_shift;
      logic signed [DATA_W-1:0]   mix_next;
      logic signed [DATA_W-1:0]   mix_reg;
      logic signed [LPF_W-1:0]    mix_ext;
      logic signed [LPF_W-1:0]    diff;
      logic signed [LPF_W-1:0]    lpf_next;
      logic signed [LPF_W-1:0]    lpf_reg;

      assign carrier    = (gi == 0) ? nco_carrier_i : nco_carrier_q;
      assign prod       = data_d_reg * carrier;
      assign prod_shift = prod >>> (DATA_W - 1);
      // Only -1 x -1 lands above the Q1.15 range; pin it to +max.
      assign mix_next   = (prod_shift > PROD_MAX) ? MIX_MAX : prod_shift[DATA_W-1:0];

      assign mix_ext  = {{2{mix_reg[DATA_W-1]}}, mix_reg};
      assign diff     = mix_ext - lpf_reg;
      assign lpf_next = lpf_reg + (diff >>> LPF_SHIFT);

      // Register the mixer product and advance the arm low-pass filter.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mix_reg <= '0;
          lpf_reg <= '0;
        end else begin
          mix_reg <= mix_next;
          lpf_reg <= lpf_next;
        end
      end
    end
  endgenerate

  assign lpf_i = g_arm[0].lpf_reg;
  assign lpf_q = g_arm[1].lpf_reg;

  // ---------------------------------------------------------------------
  // Decision-directed phase detector and PI loop filter.
  // ---------------------------------------------------------------------
  always_comb begin
    err_wide = lpf_i[LPF_W-1] ? -lpf_q : lpf_q;
    if (err_wide > ERR_MAX)      err = ERR_MAX[DATA_W-1:0];
    else if (err_wide < ERR_MIN) err = ERR_MIN[DATA_W-1:0];
    else                         err = err_wide[DATA_W-1:0];
  end

  assign err_ext   = {{(ACC_W-DATA_W){err[DATA_W-1]}}, err};
  assign kp_term   = err_ext >>> KP_SHIFT;
  assign ki_term   = err_ext >>> KI_SHIFT;
  assign integ_sum = {integ_reg[ACC_W-1], integ_reg} + {ki_term[ACC_W-1], ki_term};
  assign ctrl      = kp_term + integ_reg;

  // Clamp the integrator so a lost signal cannot wind the NCO arbitrarily far.
  always_comb begin
    if (integ_sum > INTEG_MAX)      integ_next = INTEG_MAX[ACC_W-1:0];
    else if (integ_sum < INTEG_MIN) integ_next = INTEG_MIN[ACC_W-1:0];
    else                            integ_next = integ_sum[ACC_W-1:0];
  end

  // Loop integrator state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) integ_reg <= '0;
    else     integ_reg <= integ_next;
  end

  // Hard decision: 1 when the filtered I arm is non-negative.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_out_reg <= 1'b0;
    else     data_out_reg <= ~lpf_i[LPF_W-1];
  end

  assign data_out = data_out_reg;

`ifdef BPSK_DEMOD_LOCK_DETECT_EN
  // ---------------------------------------------------------------------
  // Lock detect: I energy dominating Q by 2x for 64 straight cycles.
  // ---------------------------------------------------------------------
  logic signed [LPF_W-1:0] abs_i;
  logic signed [LPF_W-1:0] abs_q;
  logic                    lock_ok;
  logic        [5:0]       lock_cnt_reg;
  logic                    locked_reg;

  assign abs_i   = lpf_i[LPF_W-1] ? -lpf_i : lpf_i;
  assign abs_q   = lpf_q[LPF_W-1] ? -lpf_q : lpf_q;
  assign lock_ok = {1'b0, abs_i} > {abs_q, 1'b0};

  // Count consecutive qualifying cycles; any miss restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt_reg <= '0;
      locked_reg   <= 1'b0;
    end else if (!lock_ok) begin
      lock_cnt_reg <= '0;
      locked_reg   <= 1'b0;
    end else if (lock_cnt_reg == 6'd63) begin
      locked_reg   <= 1'b1;
    end else begin
      lock_cnt_reg <= lock_cnt_reg + 6'd1;
    end
  end

  assign locked = locked_reg;
`endif

endmodule

// File: tb/tb_bpsk_demodulator.sv
// tb_bpsk_demodulator: directed bench for bpsk_demodulator.
// Carriers come either from constants (mixer/LPF vectors) or from a
// cosine LUT model with one clock of read latency (tracking run).
`timescale 1ns/1ps
module tb_bpsk_demodulator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] data_in = '0;
  logic               data_out;
  logic        [11:0] i_idx;
  logic        [11:0] q_idx;
  logic signed [15:0] nco_carrier_i = '0;
  logic signed [15:0] nco_carrier_q = '0;
`ifdef BPSK_DEMOD_LOCK_DETECT_EN
  logic               locked;
`endif

  bpsk_demodulator dut (
    .clk                         (clk),
    .rst                         (rst),
    .data_in                     (data_in),
    .data_out                    (data_out),
    .nco_i_cosine_lu_angle_steps (i_idx),
    .nco_q_cosine_lu_angle_steps (q_idx),
    .nco_carrier_i               (nco_carrier_i),
    .nco_carrier_q               (nco_carrier_q)
`ifdef BPSK_DEMOD_LOCK_DETECT_EN
    ,
    .locked                      (locked)
`endif
  );

  always #5 clk = ~clk;

  // Carrier source: LUT model (1-clk read) or fixed constants.
  int                 lut [4096];
  logic               lut_mode = 1'b0;
  logic signed [15:0] ci_const = '0;
  logic signed [15:0] cq_const = '0;

  always @(posedge clk) begin
    if (lut_mode) begin
      nco_carrier_i <= 16'(lut[i_idx]);
      nco_carrier_q <= 16'(lut[q_idx]);
    end else begin
      nco_carrier_i <= ci_const;
      nco_carrier_q <= cq_const;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic signed [15:0] data;
    logic signed [15:0] ci;
    logic               exp_out;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int exp_i;
    logic bit_val;

    // Mixer/LPF vectors; Q carrier is 0 so the loop stays idle.
    vecs[0] = '{ 16384,  16384, 1'b1};
    vecs[1] = '{ 16384, -16384, 1'b0};
    vecs[2] = '{-20000,  30000, 1'b0};
    vecs[3] = '{-20000, -30000, 1'b1};
    vecs[4] = '{-32768, -32768, 1'b1};  // saturates to +32767
    vecs[5] = '{-32768,  32767, 1'b0};
    vecs[6] = '{     1,      1, 1'b1};  // product truncates to 0
    vecs[7] = '{    -1,      1, 1'b0};  // product floors to -1
    vecs[8] = '{     0, -32768, 1'b1};
    vecs[9] = '{ 32767,  32767, 1'b1};

    for (int k = 0; k < 4096; k++)
      lut[k] = $rtoi(32767.0 * $cos(2.0 * 3.14159265358979 * real'(k) / 4096.0));

    // Reset held 3 clocks with random samples.
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_in = 16'($urandom);
      step();
    end
    check("reset data_out", int'(data_out), 0);
    check("reset i_idx", int'(i_idx), 0);
    check("reset q_idx", int'(q_idx), 0);
    $display("reset: data_out=%0d i_idx=%0d q_idx=%0d", data_out, i_idx, q_idx);

    // Free run with no signal: NCO steps 512 per clk and wraps 4095->0.
    data_in = '0;
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_i = (512 * k) % 4096;
      check("freerun i_idx", int'(i_idx), exp_i);
      check("freerun q_idx", int'(q_idx), (exp_i + 3072) % 4096);
      check("freerun data_out", int'(data_out), 1);
      $display("freerun clk %0d: i_idx=%0d q_idx=%0d", k, i_idx, q_idx);
    end

    // Asynchronous reset mid-run clears state without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async rst i_idx", int'(i_idx), 0);
    check("async rst q_idx", int'(q_idx), 0);
    check("async rst data_out", int'(data_out), 0);
    $display("async reset: i_idx=%0d q_idx=%0d data_out=%0d", i_idx, q_idx, data_out);

    // Pipeline latency: a negative I product reaches data_out on clk 4.
    data_in  = -16'sd16384;
    ci_const = 16'sd16384;
    cq_const = '0;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("latency data_out", int'(data_out), (k < 4) ? 1 : 0);
      $display("latency clk %0d: data_out=%0d", k, data_out);
    end

    // Table-driven mixer / saturation / sign vectors.
    foreach (vecs[v]) begin
      rst      = 1'b1;
      data_in  = vecs[v].data;
      ci_const = vecs[v].ci;
      cq_const = '0;
      step();
      step();
      rst = 1'b0;
      repeat (20) step();
      check("vec data_out", int'(data_out), int'(vecs[v].exp_out));
      check("vec i_idx", int'(i_idx), 2048);
      $display("vec %0d: data=%0d ci=%0d data_out=%0d i_idx=%0d",
               v, vecs[v].data, vecs[v].ci, data_out, i_idx);
    end

    // Zero-offset tracking: modulator reads the same LUT index, 20 clk/bit.
    rst      = 1'b1;
    lut_mode = 1'b1;
    data_in  = '0;
    step();
    rst = 1'b0;
    for (int n = 0; n < 220; n++) begin
      bit_val = ((n / 20) % 2) == 0;
      data_in = bit_val ? 16'(lut[i_idx]) : 16'(-lut[i_idx]);
      step();
      check("track q_idx", int'(q_idx), (int'(i_idx) + 3072) % 4096);
      if (n % 20 == 18) begin
        check("track data_out", int'(data_out), int'(bit_val));
        $display("track bit %0d: sent=%0d data_out=%0d i_idx=%0d",
                 n / 20, bit_val, data_out, i_idx);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
